// File: rtl/tac_signed_array.sv
// NCH-channel signed time-domain accumulator with snapshot shadows and a valid/ready drain port.
// Define TAC_SAT_EN to clamp each {msb,lsb} counter as a signed value instead of wrapping.
module tac_signed_array #(
  parameter int NCH   = 4,
  parameter int W_W   = 8,
  parameter int LSB_W = 12,
  parameter int MSB_W = 6,
  parameter int CH_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 tac_in,
  input  logic                 sign_x,
  input  logic [NCH*W_W-1:0]   tac_w,
  input  logic [NCH-1:0]       sign_w,
  input  logic                 snap,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CH_W-1:0]      out_ch,
  output logic [LSB_W-1:0]     out_lsb,
  output logic [MSB_W-1:0]     out_msb
);

  // state | meaning
  // ACCUM | counters accumulate, snap accepted
  // DRAIN | shadows stream out one channel per handshake, snap ignored
  localparam int CNT_W = MSB_W + LSB_W;

  typedef enum logic [0:0] {ACCUM = 1'b0, DRAIN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   out_ch_q, ch_d;
  logic [CNT_W-1:0]  cnt     [NCH];
  logic [CNT_W-1:0]  cnt_nxt [NCH];
  logic [CNT_W-1:0]  shadow  [NCH];
  logic              take;
  logic              pulse;

  assign take  = (state_q == ACCUM) && snap;
  assign pulse = en & tac_in;

  genvar g;
  for (g = 0; g < NCH; g++) begin : g_ch
    logic [W_W-1:0]   w;
    logic             pos;
    logic [CNT_W-1:0] base;
    logic [CNT_W-1:0] upd;

    assign w    = tac_w[g*W_W +: W_W];
    assign pos  = ~(sign_x ^ sign_w[g]);
    // A snapshot clears the live counter, but that cycle's pulse still lands on zero.
    assign base = take ? '0 : cnt[g];

`ifdef TAC_SAT_EN
    logic [CNT_W:0] s;
    assign s   = pos ? {base[CNT_W-1], base} + (CNT_W+1)'(w)
                     : {base[CNT_W-1], base} - (CNT_W+1)'(w);
    assign upd = (s[CNT_W] != s[CNT_W-1])
                 ? (s[CNT_W] ? {1'b1, {(CNT_W-1){1'b0}}} : {1'b0, {(CNT_W-1){1'b1}}})
                 : s[CNT_W-1:0];
`else
    logic [LSB_W:0]   ls;
    logic [MSB_W-1:0] mn;
    assign ls  = pos ? {1'b0, base[LSB_W-1:0]} + (LSB_W+1)'(w)
                     : {1'b0, base[LSB_W-1:0]} - (LSB_W+1)'(w);
    assign mn  = ls[LSB_W] ? (pos ? base[CNT_W-1:LSB_W] + MSB_W'(1)
                                  : base[CNT_W-1:LSB_W] - MSB_W'(1))
                           : base[CNT_W-1:LSB_W];
    assign upd = {mn, ls[LSB_W-1:0]};
`endif

    assign cnt_nxt[g] = pulse ? upd : base;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ACCUM;
      out_ch_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]    <= '0;
        shadow[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      out_ch_q <= ch_d;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (take) shadow[i] <= cnt[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = out_ch_q;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        if (snap) begin
          state_d = DRAIN;
          ch_d    = '0;
        end
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (out_ch_q == CH_W'(NCH-1)) begin
            state_d = ACCUM;
            ch_d    = '0;
          end else begin
            ch_d = out_ch_q + CH_W'(1);
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  assign out_ch  = out_ch_q;
  assign out_lsb = shadow[out_ch_q][LSB_W-1:0];
  assign out_msb = shadow[out_ch_q][CNT_W-1:LSB_W];

endmodule
